fc_snoop_framer: RTL and testbench

Frame delimiter and idle filter that sits directly upstream of the stream capture stage on each snooped Fibre Channel port. Takes the raw 36-bit word stream from the PHY side ({ctrl[3:0], data[31:0]}, ctrl bit i flags byte i as a K-character) and forwards only frame content: SOF, payload words and EOF. Idles and primitive signals are dropped. Frames that exceed the FC maximum length are truncated with an abort marker. Output is a registered valid-only stream with no backpressure, which feeds the capture port directly.

---
 rtl/fc_snoop_pkg.sv | 18 +
 rtl/fc_os_classify.sv | 21 ++
 rtl/fc_snoop_framer.sv | 114 +++++++++++
 tb/tb_fc_snoop_framer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_snoop_pkg.sv
// rtl/fc_snoop_pkg.sv - shared constants, word-class and state enums for the FC snoop framer
package fc_snoop_pkg;

  localparam logic [7:0]  K28_5      = 8'hBC;
  localparam logic [7:0]  SOF_ID     = 8'hB5;
  localparam logic [7:0]  EOF_ID     = 8'h95;
  localparam logic [3:0]  OS_CTRL    = 4'b1000;
  localparam logic [35:0] ABORT_WORD = {OS_CTRL, K28_5, EOF_ID, 16'hF5F5};

  typedef enum logic [1:0] {WC_DATA, WC_SOF, WC_EOF, WC_PRIM} word_class_e;

  typedef enum logic [1:0] {ST_HUNT, ST_IN_FRAME, ST_DROP} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fc_os_classify.sv
// rtl/fc_os_classify.sv - combinational {ctrl,data} word-class decoder for FC ordered sets
module fc_os_classify
  import fc_snoop_pkg::*;
(
  input  logic [35:0] in_data,
  output logic [1:0]  word_class
);

  always_comb begin
    word_class = WC_DATA;
    if (in_data[35:32] == OS_CTRL && in_data[31:24] == K28_5) begin
      if (in_data[23:16] == SOF_ID)
        word_class = WC_SOF;
      else if (in_data[23:16] == EOF_ID)
        word_class = WC_EOF;
      else
        word_class = WC_PRIM;
    end
  end

endmodule

// File: rtl/fc_snoop_framer.sv
// rtl/fc_snoop_framer.sv - FC frame delimiter/idle filter with length truncation
// Frame counters are built only when FC_SNOOP_STATS_EN is defined.
module fc_snoop_framer
  import fc_snoop_pkg::*;
#(
  parameter int MAX_WORDS = 537
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        snoop_reset,
  input  logic [35:0] in_data,
  input  logic        in_valid,
  output logic [35:0] out_data,
  output logic        out_valid,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_trunc
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(MAX_WORDS - 1);

  logic [1:0]    wc;
  state_e        state;
  logic [CW-1:0] word_cnt;

  fc_os_classify u_classify (
    .in_data    (in_data),
    .word_class (wc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HUNT;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FC_SNOOP_STATS_EN
      frames_ok    <= '0;
      frames_trunc <= '0;
`endif
    end else if (snoop_reset) begin
      // out_data is left alone: it only has to hold while out_valid is low
      state     <= ST_HUNT;
      word_cnt  <= '0;
      out_valid <= 1'b0;
`ifdef FC_SNOOP_STATS_EN
      frames_ok    <= '0;
      frames_trunc <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_HUNT: begin
            if (wc == WC_SOF) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              word_cnt  <= CW'(1);
              state     <= ST_IN_FRAME;
            end
          end
          ST_IN_FRAME: begin
            if (wc == WC_DATA) begin
              out_valid <= 1'b1;
              if (word_cnt >= LAST_DATA) begin
                // no room left for the EOF: close the frame with ABORT now
                out_data <= ABORT_WORD;
                state    <= ST_DROP;
`ifdef FC_SNOOP_STATS_EN
                frames_trunc <= sat_inc(frames_trunc);
`endif
              end else begin
                out_data <= in_data;
                word_cnt <= word_cnt + 1'b1;
              end
            end else if (wc == WC_EOF) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              state     <= ST_HUNT;
`ifdef FC_SNOOP_STATS_EN
              frames_ok <= sat_inc(frames_ok);
`endif
            end else if (wc == WC_SOF) begin
              // the interrupting SOF is consumed, not reopened
              out_valid <= 1'b1;
              out_data  <= ABORT_WORD;
              state     <= ST_HUNT;
`ifdef FC_SNOOP_STATS_EN
              frames_trunc <= sat_inc(frames_trunc);
`endif
            end
          end
          ST_DROP: begin
            if (wc == WC_SOF) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              word_cnt  <= CW'(1);
              state     <= ST_IN_FRAME;
            end else if (wc == WC_EOF) begin
              state <= ST_HUNT;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

`ifndef FC_SNOOP_STATS_EN
  assign frames_ok    = 16'h0;
  assign frames_trunc = 16'h0;
`endif

endmodule

// File: tb/tb_fc_snoop_framer.sv
// tb/tb_fc_snoop_framer.sv - table-driven bench for fc_snoop_framer (MAX_WORDS=8)
module tb_fc_snoop_framer;

`ifdef FC_SNOOP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [35:0] SOF_W   = 36'h8_BCB5_5656;
  localparam logic [35:0] EOF_W   = 36'h8_BC95_7575;
  localparam logic [35:0] IDLE_W  = 36'h8_BC50_B5B5;
  localparam logic [35:0] ABORT_W = 36'h8_BC95_F5F5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        snoop_reset = 1'b0;
  logic [35:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [35:0] out_data;
  logic        out_valid;
  logic [15:0] frames_ok;
  logic [15:0] frames_trunc;

  always #5 clk = ~clk;

  fc_snoop_framer #(.MAX_WORDS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .snoop_reset  (snoop_reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .frames_ok    (frames_ok),
    .frames_trunc (frames_trunc)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic        v;
    logic [35:0] d;
    logic        ev;
    logic [35:0] ed;
    logic        chk;
    logic [15:0] eok;
    logic [15:0] etr;
  } vec_t;

  vec_t        vq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [35:0] last_d = '0;

  function automatic logic [15:0] ec(input int n);
    return STATS ? 16'(n) : 16'h0;
  endfunction

  function automatic logic [35:0] dw(input int n);
    return {4'h0, 32'hD000_0000 + 32'(n)};
  endfunction

  task automatic add(input string tag, input logic rst, input logic v, input logic [35:0] d,
                     input logic ev, input logic [35:0] ed);
    vec_t t;
    t.tag = tag; t.rst = rst; t.v = v; t.d = d; t.ev = ev; t.ed = ed;
    t.chk = 1'b0; t.eok = '0; t.etr = '0;
    vq.push_back(t);
  endtask

  task automatic pass(input string tag, input logic [35:0] d);
    add(tag, 1'b0, 1'b1, d, 1'b1, d);
  endtask

  task automatic drop(input string tag, input logic [35:0] d);
    add(tag, 1'b0, 1'b1, d, 1'b0, '0);
  endtask

  task automatic abort(input string tag, input logic [35:0] d);
    add(tag, 1'b0, 1'b1, d, 1'b1, ABORT_W);
  endtask

  task automatic gap(input string tag);
    add(tag, 1'b0, 1'b0, SOF_W, 1'b0, '0);
  endtask

  task automatic cnt(input int ok, input int tr);
    vec_t t;
    t = vq.pop_back();
    t.chk = 1'b1; t.eok = ec(ok); t.etr = ec(tr);
    vq.push_back(t);
  endtask

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) drop("idle", IDLE_W);
    cnt(0, 0);

    // longest legal frame at MAX_WORDS=8
    pass("norm", SOF_W);
    for (int i = 1; i <= 6; i++) pass("norm", dw(i));
    pass("norm", EOF_W); cnt(1, 0);
    drop("norm_idle", IDLE_W);

    pass("prim", SOF_W);
    pass("prim", dw(11)); pass("prim", dw(12));
    drop("prim", IDLE_W);
    pass("prim", dw(13)); pass("prim", dw(14));
    pass("prim", EOF_W); cnt(2, 0);

    pass("stray", SOF_W);
    pass("stray", 36'h1_0000_00BC);
    pass("stray", 36'hC_BCB5_0000);
    pass("stray", 36'h8_BD95_0000);
    pass("stray", EOF_W); cnt(3, 0);

    pass("trunc", SOF_W);
    for (int i = 1; i <= 6; i++) pass("trunc", dw(20 + i));
    abort("trunc", dw(27)); cnt(3, 1);
    for (int i = 0; i < 5; i++) drop("trunc_drop", dw(30 + i));
    drop("trunc_eof", EOF_W); cnt(3, 1);
    drop("trunc_hunt", dw(40));

    pass("sof2", SOF_W);
    for (int i = 1; i <= 3; i++) pass("sof2", dw(50 + i));
    abort("sof2", SOF_W); cnt(3, 2);
    drop("sof2_drop", dw(54)); drop("sof2_drop", dw(55));
    drop("sof2_eof", EOF_W); cnt(3, 2);

    pass("dropsof", SOF_W);
    for (int i = 1; i <= 6; i++) pass("dropsof", dw(60 + i));
    abort("dropsof", dw(67));
    drop("dropsof", dw(68));
    pass("dropsof", SOF_W);
    pass("dropsof", dw(69));
    pass("dropsof", EOF_W); cnt(4, 3);

    pass("gap", SOF_W);
    gap("gap"); gap("gap"); gap("gap");
    pass("gap", dw(71));
    gap("gap"); gap("gap"); gap("gap");
    pass("gap", dw(72));
    pass("gap", EOF_W); cnt(5, 3);

    pass("srst", SOF_W);
    pass("srst", dw(81));
    add("srst", 1'b1, 1'b1, dw(82), 1'b0, '0); cnt(0, 0);
    drop("srst_hunt", dw(83)); drop("srst_hunt", dw(84));
    drop("srst_eof", EOF_W); cnt(0, 0);
    pass("after", SOF_W); pass("after", dw(85));
    pass("after", EOF_W); cnt(1, 0);

    // hard reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", {35'h0, out_valid}, 36'h0);
    check("rst_data", out_data, 36'h0);
    check("rst_ok", {20'h0, frames_ok}, 36'h0);
    check("rst_trunc", {20'h0, frames_trunc}, 36'h0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      snoop_reset = vq[i].rst;
      in_valid    = vq[i].v;
      in_data     = vq[i].d;
      @(posedge clk); #1;
      if (vq[i].ev) last_d = vq[i].ed;
      nvec++;
      if (out_valid !== vq[i].ev || out_data !== last_d ||
          (vq[i].chk && (frames_ok !== vq[i].eok || frames_trunc !== vq[i].etr))) begin
        nerr++;
        $display("FAIL %s[%0d] valid=%b data=%h ok=%0d trunc=%0d, want valid=%b data=%h ok=%0d trunc=%0d",
                 vq[i].tag, i, out_valid, out_data, frames_ok, frames_trunc,
                 vq[i].ev, last_d, vq[i].eok, vq[i].etr);
      end
    end

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    snoop_reset = 1'b0; in_valid = 1'b1; in_data = SOF_W;
    @(posedge clk); #1;
    check("ar_sof", {35'h0, out_valid}, 36'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", {35'h0, out_valid}, 36'h0);
    check("ar_data", out_data, 36'h0);
    check("ar_ok", {20'h0, frames_ok}, 36'h0);
    @(negedge clk);
    reset_n = 1'b1; in_data = dw(90);
    @(posedge clk); #1;
    check("ar_hunt", {35'h0, out_valid}, 36'h0);
    @(negedge clk);
    in_data = SOF_W;
    @(posedge clk); #1;
    check("ar_resof", out_valid ? out_data : 36'hF_FFFF_FFFF, SOF_W);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ar_idle", {35'h0, out_valid}, 36'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
